// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axi_lite_cmd_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width needed to hold 0..limit; a disabled timeout (limit 0) still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/axi_lite_cmd_timeout.sv
// Transaction watchdog: up-counter with synchronous clear (load of zero) and enable.
module axi_lite_cmd_timeout
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int unsigned LIMIT = 1024,
  parameter int unsigned WIDTH = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  // Fires during the LIMIT-th enabled cycle so the abort lands on that edge.
  assign expired = (LIMIT != 0) && en && (count == LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: one single-beat command in flight, with watchdog-forced response.
module axi_lite_cmd_master
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [2:0]  AXI_PROT       = 3'b000
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);

  state_t state;
  logic   cmd_hs;
  logic   cnt_en;
  logic   timeout_hit;
  logic   resp_beat;
  logic   aw_done;
  logic   w_done;

  assign m_axi_awprot = AXI_PROT;
  assign m_axi_arprot = AXI_PROT;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign cnt_en    = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_RESP);
  assign resp_beat = (m_axi_bvalid && m_axi_bready) || (m_axi_rvalid && m_axi_rready);
  assign aw_done   = !m_axi_awvalid || m_axi_awready;
  assign w_done    = !m_axi_wvalid  || m_axi_wready;

  axi_lite_cmd_timeout #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (cnt_width(TIMEOUT_CYCLES))
  ) u_timeout (
    .clk     (axi_aclk),
    .rst     (axi_areset),
    .clr     (cmd_hs),
    .en      (cnt_en),
    .expired (timeout_hit)
  );

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_araddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      rsp_timeout   <= 1'b0;
    end else if (timeout_hit && !resp_beat) begin
      // A B/R beat on the expiry cycle wins; otherwise abandon the bus transaction.
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b1;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_SLVERR;
      rsp_timeout   <= 1'b1;
      state         <= RSP;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_hs) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_wstrb   <= cmd_wstrb;
              state         <= WR_REQ;
            end else begin
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= cmd_addr;
              state         <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            rsp_timeout  <= 1'b0;
            state        <= RSP;
          end
        end
        RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_timeout  <= 1'b0;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with an 8-cycle watchdog and a hand-driven slave.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (8),
    .AXI_PROT       (3'b000)
  ) dut (
    .axi_aclk (clk), .axi_areset (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
    .rsp_resp (rsp_resp), .rsp_timeout (rsp_timeout),
    .m_axi_awvalid (awvalid), .m_axi_awready (awready), .m_axi_awaddr (awaddr), .m_axi_awprot (awprot),
    .m_axi_wvalid (wvalid), .m_axi_wready (wready), .m_axi_wdata (wdata), .m_axi_wstrb (wstrb),
    .m_axi_bvalid (bvalid), .m_axi_bready (bready), .m_axi_bresp (bresp),
    .m_axi_arvalid (arvalid), .m_axi_arready (arready), .m_axi_araddr (araddr), .m_axi_arprot (arprot),
    .m_axi_rvalid (rvalid), .m_axi_rready (rready), .m_axi_rdata (rdata), .m_axi_rresp (rresp)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick; tick;
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    vectors++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin miscompares++; $display("FAIL rst_axi_ctl got %b exp 00000", {awvalid, wvalid, bready, arvalid, rready}); end
    vectors++; if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b0) begin miscompares++; $display("FAIL rst_rsp_ctl got %b exp 0000", {rsp_valid, rsp_timeout, rsp_resp}); end
    vectors++; if ({awaddr, araddr, wdata, wstrb, rsp_rdata} !== '0) begin miscompares++; $display("FAIL rst_data got nonzero exp 0"); end
    rst = 1'b0;
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_rel_cmd_ready got %b exp 0", cmd_ready); end
    tick;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_rise_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] br);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL wr_c0_cmd_ready got %b exp 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick;
    cmd_valid = 1'b0;
    vectors++; if ({awvalid, wvalid, cmd_ready} !== 3'b110) begin miscompares++; $display("FAIL wr_c1_valids got %b exp 110", {awvalid, wvalid, cmd_ready}); end
    vectors++; if (awaddr !== a) begin miscompares++; $display("FAIL wr_c1_awaddr got %h exp %h", awaddr, a); end
    vectors++; if ({wdata, wstrb} !== {d, s}) begin miscompares++; $display("FAIL wr_c1_wdata got %h/%h exp %h/%h", wdata, wstrb, d, s); end
    awready = 1'b1; wready = 1'b1;
    tick;
    awready = 1'b0; wready = 1'b0;
    vectors++; if ({awvalid, wvalid, bready} !== 3'b001) begin miscompares++; $display("FAIL wr_c2_ctl got %b exp 001", {awvalid, wvalid, bready}); end
    bvalid = 1'b1; bresp = br;
    tick;
    bvalid = 1'b0;
    vectors++; if ({rsp_valid, bready, rsp_timeout} !== 3'b100) begin miscompares++; $display("FAIL wr_c3_ctl got %b exp 100", {rsp_valid, bready, rsp_timeout}); end
    vectors++; if ({rsp_resp, rsp_rdata} !== {br, 32'h0}) begin miscompares++; $display("FAIL wr_c3_rsp got %b/%h exp %b/0", rsp_resp, rsp_rdata, br); end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    vectors++; if ({rsp_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL wr_c4_ctl got %b exp 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rd_c0_cmd_ready got %b exp 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
    tick;
    cmd_valid = 1'b0;
    vectors++; if ({arvalid, awvalid, cmd_ready} !== 3'b100) begin miscompares++; $display("FAIL rd_c1_ctl got %b exp 100", {arvalid, awvalid, cmd_ready}); end
    vectors++; if (araddr !== a) begin miscompares++; $display("FAIL rd_c1_araddr got %h exp %h", araddr, a); end
    arready = 1'b1;
    tick;
    arready = 1'b0;
    vectors++; if ({arvalid, rready} !== 2'b01) begin miscompares++; $display("FAIL rd_c2_ctl got %b exp 01", {arvalid, rready}); end
    rvalid = 1'b1; rdata = d; rresp = rr;
    tick;
    rvalid = 1'b0;
    vectors++; if ({rsp_valid, rready, rsp_timeout} !== 3'b100) begin miscompares++; $display("FAIL rd_c3_ctl got %b exp 100", {rsp_valid, rready, rsp_timeout}); end
    vectors++; if ({rsp_rdata, rsp_resp} !== {d, rr}) begin miscompares++; $display("FAIL rd_c3_rsp got %h/%b exp %h/%b", rsp_rdata, rsp_resp, d, rr); end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    vectors++; if ({rsp_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL rd_c4_ctl got %b exp 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_write_zero_wait;
    do_write(32'h9C40_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
  endtask

  task automatic test_write_aw_delay;
    int aw_cycles = 0;
    int w_cycles = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h9C40_0014; cmd_wdata = 32'h0000_1234; cmd_wstrb = 4'h5;
    tick;
    cmd_valid = 1'b0;
    wready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (awvalid === 1'b1) aw_cycles++;
      if (wvalid === 1'b1) w_cycles++;
      awready = (c == 4);
      tick;
      wready = 1'b0;
    end
    awready = 1'b0;
    vectors++; if (aw_cycles != 4) begin miscompares++; $display("FAIL awd_aw_cycles got %0d exp 4", aw_cycles); end
    vectors++; if (w_cycles != 1) begin miscompares++; $display("FAIL awd_w_cycles got %0d exp 1", w_cycles); end
    vectors++; if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin miscompares++; $display("FAIL awd_c5_ctl got %b exp 0010", {awvalid, wvalid, bready, rsp_valid}); end
    bvalid = 1'b1; bresp = 2'b01;
    tick;
    vectors++; if ({rsp_valid, bready} !== 2'b10) begin miscompares++; $display("FAIL awd_c6_single_b got %b exp 10", {rsp_valid, bready}); end
    vectors++; if (rsp_resp !== 2'b01) begin miscompares++; $display("FAIL awd_c6_resp got %b exp 01", rsp_resp); end
    bvalid = 1'b0; rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    vectors++; if ({rsp_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL awd_c7_ctl got %b exp 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_read;
    do_read(32'h9902_0000, 32'h00A5_A5A5, 2'b11);
  endtask

  task automatic test_timeout;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h9C40_0020; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
    tick;
    cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    tick;
    awready = 1'b0; wready = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      vectors++; if ({bready, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL to_wait_c%0d got %b exp 10", c, {bready, rsp_valid}); end
      tick;
    end
    vectors++; if ({bready, rsp_valid, rsp_timeout} !== 3'b011) begin miscompares++; $display("FAIL to_c9_ctl got %b exp 011", {bready, rsp_valid, rsp_timeout}); end
    vectors++; if ({rsp_resp, rsp_rdata} !== {2'b10, 32'h0}) begin miscompares++; $display("FAIL to_c9_rsp got %b/%h exp 10/0", rsp_resp, rsp_rdata); end
    bvalid = 1'b1; bresp = 2'b00; rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    vectors++; if ({bready, rsp_valid, cmd_ready} !== 3'b001) begin miscompares++; $display("FAIL to_late_b got %b exp 001", {bready, rsp_valid, cmd_ready}); end
    tick;
    vectors++; if ({bready, rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL to_late_b2 got %b exp 00", {bready, rsp_valid}); end
    bvalid = 1'b0;
    do_read(32'h9902_0008, 32'hCAFE_F00D, 2'b00);
  endtask

  task automatic test_timeout_race;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h9C40_0024; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    tick;
    cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    tick;
    awready = 1'b0; wready = 1'b0;
    for (int c = 2; c <= 7; c++) tick;
    bvalid = 1'b1; bresp = 2'b01;
    tick;
    bvalid = 1'b0;
    vectors++; if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b1001) begin miscompares++; $display("FAIL race_rsp got %b exp 1001", {rsp_valid, rsp_timeout, rsp_resp}); end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    vectors++; if ({rsp_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL race_done got %b exp 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_backpressure;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h9902_0010;
    tick;
    arready = 1'b1;
    cmd_write = 1'b1; cmd_addr = 32'h9C40_0030; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'h3;
    tick;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1357_2468; rresp = 2'b00;
    tick;
    rvalid = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      vectors++; if ({rsp_valid, cmd_ready, rsp_rdata, rsp_resp} !== {2'b10, 32'h1357_2468, 2'b00}) begin miscompares++; $display("FAIL bp_hold_c%0d got %b/%b/%h exp 1/0/13572468", c, rsp_valid, cmd_ready, rsp_rdata); end
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    vectors++; if ({rsp_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL bp_release got %b exp 01", {rsp_valid, cmd_ready}); end
    tick;
    cmd_valid = 1'b0;
    vectors++; if ({awvalid, cmd_ready, awaddr, wstrb} !== {2'b10, 32'h9C40_0030, 4'h3}) begin miscompares++; $display("FAIL bp_next_cmd got %b/%h/%h exp 10/9c400030/3", {awvalid, cmd_ready}, awaddr, wstrb); end
    awready = 1'b1; wready = 1'b1;
    tick;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    tick;
    bvalid = 1'b0; rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    vectors++; if ({rsp_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL bp_next_done got %b exp 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_back_to_back;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h9C40_0040; cmd_wdata = 32'hA5A5_0001; cmd_wstrb = 4'hF;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      vectors++; if ({cmd_ready, rsp_valid} !== {c % 4 == 0, c % 4 == 3}) begin miscompares++; $display("FAIL b2b_c%0d got %b exp %b", c, {cmd_ready, rsp_valid}, {c % 4 == 0, c % 4 == 3}); end
      tick;
    end
    cmd_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rsp_ready = 1'b0;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_end got %b exp 1", cmd_ready); end
    tick;
  endtask

  task automatic test_reset_mid;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h9902_0004;
    tick;
    cmd_valid = 1'b0;
    vectors++; if (arvalid !== 1'b1) begin miscompares++; $display("FAIL rm_pre_arvalid got %b exp 1", arvalid); end
    #2 rst = 1'b1;
    #1;
    vectors++; if ({arvalid, rready, cmd_ready, rsp_valid} !== 4'b0) begin miscompares++; $display("FAIL rm_async got %b exp 0000", {arvalid, rready, cmd_ready, rsp_valid}); end
    tick; tick;
    rst = 1'b0;
    tick;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rm_cmd_ready got %b exp 1", cmd_ready); end
    do_read(32'h9902_000C, 32'h8765_4321, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write_zero_wait;
    test_write_aw_delay;
    test_read;
    test_timeout;
    test_timeout_race;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

AXI4-Lite initiator that turns a simple single-beat command/response stream into AXI4-Lite write and read transactions. It drives the register crossbar feeding the AD9361x2 PL subsystem (DMAC and AD9361 core register windows) from fabric logic such as boot-time sequencers or test harnesses, with no PS involvement. One transaction is outstanding at a time. A programmable timeout guarantees that a response is always returned.

## Interface
- ADDR_WIDTH, 32, AXI address and cmd_addr width
- TIMEOUT_CYCLES, 1024, cycles allowed from AXI issue to B/R handshake; 0 disables the timeout
- AXI_PROT, 3'b000, constant driven on awprot/arprot
- axi_aclk  in  1  sole clock; all logic is on its rising edge
- axi_areset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  AXI BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  transaction abandoned by timeout
- m_axi_awvalid/awready/awaddr/awprot  out/in/out/out  1/1/ADDR_WIDTH/3  write address channel
- m_axi_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/4  write data channel
- m_axi_bvalid/bready/bresp  in/out/in  1/1/2  write response channel
- m_axi_arvalid/arready/araddr/arprot  out/in/out/out  1/1/ADDR_WIDTH/3  read address channel
- m_axi_rvalid/rready/rdata/rresp  in/out/in/in  1/1/32/2  read data channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. A cmd handshake registers addr, wdata, wstrb and write, then moves to WR_REQ if write, else RD_REQ.
- WR_REQ: awvalid and wvalid both assert. Each channel deasserts independently on its own handshake. Once both handshakes have completed (same cycle or different cycles), move to WR_RESP.
- WR_RESP: bready=1. On bvalid, capture bresp, set rdata=0, and move to RSP.
- RD_REQ: arvalid=1. On arready, move to RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata and rresp, and move to RSP.
- RSP: rsp_valid=1 with fields held stable. On rsp_ready, clear rsp_valid and return to IDLE.
- AXI address, data and strobe outputs hold the registered command values until their channel's handshake completes.
- Timeout counter:
  - Clears on the cmd handshake and increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches TIMEOUT_CYCLES, all AXI valids and readies drop, rsp_resp=2'b10, rsp_timeout=1, rdata=0, and the state moves to RSP.
  - A B or R beat arriving in the same cycle as the timeout takes priority: the response is normal and rsp_timeout=0.
- Late B or R beats after a timeout are not accepted, because bready and rready are low outside WR_RESP and RD_RESP.
- Response codes pass through unmodified (OKAY, EXOKAY, SLVERR, DECERR).

## Timing
- Reset values: every AXI valid and ready output is 0; addr, data, strb and rsp_* are 0; cmd_ready=0 while axi_areset is high; state is IDLE.
- cmd_ready rises on the first clock edge after reset deassertion.
- AXI valids assert the cycle after the cmd handshake (registered outputs, no combinational path from cmd to AXI).
- Write with zero-wait slave: cmd handshake in cycle 0; AW/W in cycle 1; B in cycle 2; rsp_valid in cycle 3.
- Read with zero-wait slave: cmd in cycle 0; AR in cycle 1; R in cycle 2; rsp_valid in cycle 3.
- Throughput, zero-wait slave with rsp_ready tied high: 1 transaction per 4 cycles.
- cmd_ready is low in every state other than IDLE.
- Asserting reset mid-transaction clears all outputs asynchronously. Any outstanding AXI transaction is abandoned, and the slave side must also be reset.

## Structure
- Package axi_lite_cmd_master_pkg:
  - state enum;
  - RESP_OKAY, RESP_EXOKAY, RESP_SLVERR and RESP_DECERR constants;
  - counter width derived as clog2(TIMEOUT_CYCLES+1).
- Sub-module axi_lite_cmd_timeout: loadable up-counter with clear, enable and expired outputs, instantiated once.

## Test plan
- Write 0xDEADBEEF, wstrb 4'hF, to 0x9C400010 against a zero-wait slave → awaddr=0x9C400010 and wdata=0xDEADBEEF in cycle 1; rsp_valid in cycle 3 with rsp_resp=0 and rsp_rdata=0.
- Write where awready is delayed 3 cycles and wready 0 cycles → wvalid drops after 1 cycle and awvalid stays high 4 cycles; exactly one B is accepted and one rsp is produced.
- Read from 0x99020000 with slave rdata 0x00A5A5A5 and rresp 2'b11 → rsp_rdata=0x00A5A5A5, rsp_resp=2'b11, rsp_timeout=0.
- TIMEOUT_CYCLES=8 against a slave that never asserts bvalid → bready drops on the 8th counted cycle; rsp_resp=2'b10 and rsp_timeout=1; a later bvalid is ignored and the next command completes normally.
- rsp_ready held low for 5 cycles with cmd_valid held high → rsp fields stay stable and cmd_ready stays 0; the next command is accepted the cycle after the rsp handshake.
- axi_areset pulsed while arvalid=1 → arvalid goes to 0 immediately; after release, cmd_ready=1 and a fresh read completes.
